mod_n_down_counter: RTL and testbench

MOD_N_DOWN_COUNTER -- requirements
Module: mod_N_down_counter

---
 rtl/mod_n_down_counter_if.sv | 23 ++
 rtl/mod_n_down_counter.sv | 95 +++++++++
 tb/tb_mod_n_down_counter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_down_counter_if.sv
// Control and status bundle for mod_n_down_counter.
// en and load are level strobes sampled on every rising edge; there is no ready, so every edge is accepted.
interface mod_n_down_counter_if #(
    parameter int N_BITS = 3
);
    logic              en;
    logic              load;
    logic [N_BITS-1:0] load_val;
    logic [N_BITS-1:0] count;
    logic              done;
    logic              tc;
    logic              busy;

    modport master (
        output en, load, load_val,
        input  count, done, tc, busy
    );

    modport slave (
        input  en, load, load_val,
        output count, done, tc, busy
    );
endinterface

// File: rtl/mod_n_down_counter.sv
// Modulo-N down counter with load, enable, terminal-count pulse and optional one-shot stop.
// State is exported on o_state for observation only.
module mod_n_down_counter #(
    parameter int N        = 8,
    parameter int N_BITS   = 3,
    parameter bit ONE_SHOT = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mod_n_down_counter_if.slave   bus,
    output logic [1:0]            o_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [N_BITS-1:0] MAX_CNT = N_BITS'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_BITS-1:0] r_count;
    logic [N_BITS-1:0] w_count_nxt;
    logic              r_tc;
    logic              w_tc_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic [N_BITS-1:0] w_clamped;

    // Out-of-range load values saturate at N-1 rather than wrapping.
    assign w_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_count <= MAX_CNT;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_count_nxt = w_clamped;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.load) begin
                    w_count_nxt = w_clamped;
                end else if (bus.en) begin
                    if (r_count != '0) begin
                        w_count_nxt = r_count - N_BITS'(1);
                    end else begin
                        // Decrement taken at zero: pulse tc, then wrap or stop.
                        w_tc_nxt = 1'b1;
                        if (ONE_SHOT) begin
                            w_state_nxt = EXPIRED;
                        end else begin
                            w_count_nxt = MAX_CNT;
                        end
                    end
                end
            end
            EXPIRED: begin
                w_count_nxt = '0;
                if (bus.load) begin
                    w_count_nxt = w_clamped;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == RUN);
    end

    assign bus.count = r_count;
    assign bus.done  = (r_count == '0);
    assign bus.tc    = r_tc;
    assign bus.busy  = r_busy;
    assign o_state   = r_state;
endmodule

// File: tb/tb_mod_n_down_counter.sv
// Bench for mod_n_down_counter: four configurations driven by directed scenarios and
// randomized stimulus, all checked against an arithmetic reference model.
module tb_mod_n_down_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT index: 0 = N8 wrap, 1 = N8 one-shot, 2 = N6 wrap, 3 = N1 wrap
    logic       rst_a [4];
    logic       en_a  [4];
    logic       load_a[4];
    logic [2:0] lv_a  [4];
    logic [2:0] cnt_o [4];
    logic       tc_o  [4];
    logic       busy_o[4];
    logic       done_o[4];
    logic [1:0] st_o  [4];

    int p_n [4] = '{8, 8, 6, 1};
    int p_os[4] = '{0, 1, 0, 0};

    int m_cnt[4];
    int m_ph [4];   // 0 idle, 1 running, 2 expired
    bit m_tc [4];

    int errors = 0;
    int checks = 0;
    logic [1:0] st_idle, st_run, st_exp;

    mod_n_down_counter_if #(.N_BITS(3)) bus0 ();
    mod_n_down_counter_if #(.N_BITS(3)) bus1 ();
    mod_n_down_counter_if #(.N_BITS(3)) bus2 ();
    mod_n_down_counter_if #(.N_BITS(1)) bus3 ();

    mod_n_down_counter #(.N(8), .N_BITS(3), .ONE_SHOT(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst_a[0]), .bus(bus0), .o_state(st_o[0]));
    mod_n_down_counter #(.N(8), .N_BITS(3), .ONE_SHOT(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst_a[1]), .bus(bus1), .o_state(st_o[1]));
    mod_n_down_counter #(.N(6), .N_BITS(3), .ONE_SHOT(1'b0)) dut2 (
        .i_clk(clk), .i_rst(rst_a[2]), .bus(bus2), .o_state(st_o[2]));
    mod_n_down_counter #(.N(1), .N_BITS(1), .ONE_SHOT(1'b0)) dut3 (
        .i_clk(clk), .i_rst(rst_a[3]), .bus(bus3), .o_state(st_o[3]));

    assign bus0.en = en_a[0];
    assign bus0.load = load_a[0];
    assign bus0.load_val = lv_a[0];
    assign cnt_o[0] = bus0.count;
    assign tc_o[0] = bus0.tc;
    assign busy_o[0] = bus0.busy;
    assign done_o[0] = bus0.done;

    assign bus1.en = en_a[1];
    assign bus1.load = load_a[1];
    assign bus1.load_val = lv_a[1];
    assign cnt_o[1] = bus1.count;
    assign tc_o[1] = bus1.tc;
    assign busy_o[1] = bus1.busy;
    assign done_o[1] = bus1.done;

    assign bus2.en = en_a[2];
    assign bus2.load = load_a[2];
    assign bus2.load_val = lv_a[2];
    assign cnt_o[2] = bus2.count;
    assign tc_o[2] = bus2.tc;
    assign busy_o[2] = bus2.busy;
    assign done_o[2] = bus2.done;

    assign bus3.en = en_a[3];
    assign bus3.load = load_a[3];
    assign bus3.load_val = lv_a[3][0];
    assign cnt_o[3] = {2'b00, bus3.count};
    assign tc_o[3] = bus3.tc;
    assign busy_o[3] = bus3.busy;
    assign done_o[3] = bus3.done;

    // Observed status packed as {count, tc, busy, done}
    function automatic logic [5:0] obs(int d);
        return {cnt_o[d], tc_o[d], busy_o[d], done_o[d]};
    endfunction

    function automatic logic [5:0] pk(int c, bit t, bit b);
        return {3'(c), t, b, (c == 0)};
    endfunction

    function automatic logic [5:0] mexp(int d);
        return pk(m_cnt[d], m_tc[d], (m_ph[d] == 1));
    endfunction

    function automatic void model_step(int d);
        int lv;
        lv = (d == 3) ? int'(lv_a[d][0]) : int'(lv_a[d]);
        if (!rst_a[d]) begin
            m_cnt[d] = p_n[d] - 1;
            m_ph[d]  = 0;
            m_tc[d]  = 1'b0;
        end else begin
            m_tc[d] = 1'b0;
            if (load_a[d]) begin
                m_cnt[d] = (lv > p_n[d] - 1) ? p_n[d] - 1 : lv;
                m_ph[d]  = 1;
            end else if (m_ph[d] == 1 && en_a[d]) begin
                if (m_cnt[d] > 0) begin
                    m_cnt[d] = m_cnt[d] - 1;
                end else begin
                    m_tc[d] = 1'b1;
                    if (p_os[d] != 0) m_ph[d] = 2;
                    else m_cnt[d] = p_n[d] - 1;
                end
            end
        end
    endfunction

    task automatic set_in(int d, logic r, logic l, logic [2:0] v, logic e);
        rst_a[d]  = r;
        load_a[d] = l;
        lv_a[d]   = v;
        en_a[d]   = e;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 4; d++) model_step(d);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp_rst[4];
        exp_rst = '{6'b111000, 6'b111000, 6'b101000, 6'b000001};
        for (int d = 0; d < 4; d++) set_in(d, 1'b0, 1'b1, 3'd2, 1'b1);
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs(d) !== exp_rst[d]) begin
                errors++;
                $display("FAIL reset dut%0d: got=%b exp=%b", d, obs(d), exp_rst[d]);
            end
        end
        st_idle = st_o[0];
        for (int d = 0; d < 4; d++) set_in(d, 1'b1, 1'b0, 3'd0, 1'b0);
        // en alone in IDLE must not move the count
        set_in(0, 1'b1, 1'b0, 3'd0, 1'b1);
        tick();
        checks++;
        if (obs(0) !== pk(7, 0, 0)) begin
            errors++;
            $display("FAIL idle_en_ignored: got=%b exp=%b", obs(0), pk(7, 0, 0));
        end
    endtask

    task automatic test_wrap();
        int exp_c[4] = '{2, 1, 0, 7};
        bit exp_t[4] = '{0, 0, 0, 1};
        set_in(0, 1'b1, 1'b1, 3'd3, 1'b0);
        tick();
        checks++;
        if (obs(0) !== pk(3, 0, 1)) begin
            errors++;
            $display("FAIL wrap_load: got=%b exp=%b", obs(0), pk(3, 0, 1));
        end
        set_in(0, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs(0) !== pk(exp_c[i], exp_t[i], 1)) begin
                errors++;
                $display("FAIL wrap_step%0d: got=%b exp=%b", i, obs(0), pk(exp_c[i], exp_t[i], 1));
            end
        end
        set_in(0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        checks++;
        if (obs(0) !== pk(7, 0, 1)) begin
            errors++;
            $display("FAIL wrap_tc_drop: got=%b exp=%b", obs(0), pk(7, 0, 1));
        end
    endtask

    task automatic test_en_gaps();
        logic en_seq[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   exp_c[4]  = '{1, 1, 1, 0};
        set_in(0, 1'b1, 1'b1, 3'd2, 1'b0);
        tick();
        checks++;
        if (obs(0) !== pk(2, 0, 1)) begin
            errors++;
            $display("FAIL gaps_load: got=%b exp=%b", obs(0), pk(2, 0, 1));
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b1, 1'b0, 3'd0, en_seq[i]);
            tick();
            checks++;
            if (obs(0) !== pk(exp_c[i], 0, 1)) begin
                errors++;
                $display("FAIL gaps_step%0d: got=%b exp=%b", i, obs(0), pk(exp_c[i], 0, 1));
            end
        end
    endtask

    task automatic test_reset_abort();
        // Running at count 0 with en high: reset must win, no tc
        set_in(0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        checks++;
        if (obs(0) !== pk(7, 0, 0)) begin
            errors++;
            $display("FAIL abort_reset: got=%b exp=%b", obs(0), pk(7, 0, 0));
        end
        checks++;
        if (st_o[0] !== st_idle) begin
            errors++;
            $display("FAIL abort_state: got=%b exp=%b", st_o[0], st_idle);
        end
        set_in(0, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs(0) !== pk(7, 0, 0)) begin
                errors++;
                $display("FAIL abort_hold%0d: got=%b exp=%b", i, obs(0), pk(7, 0, 0));
            end
        end
        set_in(0, 1'b1, 1'b1, 3'd4, 1'b1);
        tick();
        checks++;
        if (obs(0) !== pk(4, 0, 1)) begin
            errors++;
            $display("FAIL abort_reload: got=%b exp=%b", obs(0), pk(4, 0, 1));
        end
        set_in(0, 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_one_shot();
        logic [5:0] exp_seq[5];
        exp_seq = '{pk(1, 0, 1), pk(0, 0, 1), pk(0, 1, 0), pk(0, 0, 0), pk(0, 0, 0)};
        set_in(1, 1'b1, 1'b1, 3'd2, 1'b0);
        tick();
        checks++;
        if (obs(1) !== pk(2, 0, 1)) begin
            errors++;
            $display("FAIL oneshot_load: got=%b exp=%b", obs(1), pk(2, 0, 1));
        end
        st_run = st_o[1];
        set_in(1, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) st_exp = st_o[1];
            checks++;
            if (obs(1) !== exp_seq[i]) begin
                errors++;
                $display("FAIL oneshot_step%0d: got=%b exp=%b", i, obs(1), exp_seq[i]);
            end
        end
        checks++;
        if (st_idle === st_run || st_run === st_exp || st_idle === st_exp) begin
            errors++;
            $display("FAIL three_states: got idle=%b run=%b exp=%b required all distinct", st_idle, st_run, st_exp);
        end
        set_in(1, 1'b1, 1'b1, 3'd5, 1'b0);
        tick();
        checks++;
        if (obs(1) !== pk(5, 0, 1)) begin
            errors++;
            $display("FAIL oneshot_reload: got=%b exp=%b", obs(1), pk(5, 0, 1));
        end
        set_in(1, 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_clamp_priority();
        set_in(2, 1'b1, 1'b1, 3'd7, 1'b0);
        tick();
        checks++;
        if (obs(2) !== pk(5, 0, 1)) begin
            errors++;
            $display("FAIL clamp7: got=%b exp=%b", obs(2), pk(5, 0, 1));
        end
        set_in(2, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (obs(2) !== pk(1, 0, 1)) begin
            errors++;
            $display("FAIL clamp_count1: got=%b exp=%b", obs(2), pk(1, 0, 1));
        end
        set_in(2, 1'b1, 1'b1, 3'd3, 1'b1);
        tick();
        checks++;
        if (obs(2) !== pk(3, 0, 1)) begin
            errors++;
            $display("FAIL load_priority: got=%b exp=%b", obs(2), pk(3, 0, 1));
        end
        set_in(2, 1'b1, 1'b1, 3'd6, 1'b0);
        tick();
        checks++;
        if (obs(2) !== pk(5, 0, 1)) begin
            errors++;
            $display("FAIL clamp6: got=%b exp=%b", obs(2), pk(5, 0, 1));
        end
        set_in(2, 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_n1();
        set_in(3, 1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        checks++;
        if (obs(3) !== pk(0, 0, 1)) begin
            errors++;
            $display("FAIL n1_load: got=%b exp=%b", obs(3), pk(0, 0, 1));
        end
        set_in(3, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs(3) !== pk(0, 1, 1)) begin
                errors++;
                $display("FAIL n1_tc%0d: got=%b exp=%b", i, obs(3), pk(0, 1, 1));
            end
        end
        set_in(3, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        checks++;
        if (obs(3) !== pk(0, 0, 1)) begin
            errors++;
            $display("FAIL n1_idle_en: got=%b exp=%b", obs(3), pk(0, 0, 1));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 4; d++) begin
                set_in(d, ($urandom_range(0, 19) != 0), ($urandom_range(0, 5) == 0),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (obs(d) !== mexp(d)) begin
                    errors++;
                    $display("FAIL random c%0d dut%0d: got=%b exp=%b", c, d, obs(d), mexp(d));
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            set_in(d, 1'b0, 1'b0, 3'd0, 1'b0);
            m_cnt[d] = 0;
            m_ph[d]  = 0;
            m_tc[d]  = 1'b0;
        end
        st_idle = 2'b00;
        st_run  = 2'b00;
        st_exp  = 2'b00;
        test_reset();
        test_wrap();
        test_en_gaps();
        test_reset_abort();
        test_one_shot();
        test_clamp_priority();
        test_n1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
